// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for a single register-file write port.
// Per-requester FIFOs, round-robin grant, registered write stage, RAW pending scoreboard.

module regfile_wb_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [2**ADDR_W-1:0]   pend
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [CW-1:0]     cnt_r;
  logic [PW-1:0]     offs_s;

  function automatic logic [2**ADDR_W-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = {{(2**ADDR_W-1){1'b0}}, 1'b1} << a;
  endfunction

  assign full      = (cnt_r == CW'(DEPTH));
  assign empty     = (cnt_r == {CW{1'b0}});
  assign head_addr = addr_mem_r[rptr_r];
  assign head_data = data_mem_r[rptr_r];

  // Storage, power-of-two pointers wrap naturally, occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push) begin
        addr_mem_r[wptr_r] <= addr;
        data_mem_r[wptr_r] <= data;
        wptr_r             <= wptr_r + PW'(1);
      end
      if (pop) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry i is live when its distance from the read pointer is below the count
  always_comb begin
    pend   = {(2**ADDR_W){1'b0}};
    offs_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offs_s = PW'(i) - rptr_r;
      if ({1'b0, offs_s} < cnt_r) begin
        pend = pend | onehot(addr_mem_r[i]);
      end else begin
        pend = pend;
      end
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 hold,
  output logic                 rf_en,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 idle
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [0:0] RR_A = 1'b0;
  localparam logic [0:0] RR_B = 1'b1;

  logic              a_full_s, a_empty_s, b_full_s, b_empty_s;
  logic [ADDR_W-1:0] a_head_addr_s, b_head_addr_s;
  logic [DATA_W-1:0] a_head_data_s, b_head_data_s;
  logic [NREG-1:0]   a_pend_s, b_pend_s;
  logic              a_push_s, b_push_s;
  logic              grant_a_s, grant_b_s, contend_s;
  logic [0:0]        rr_r;
  logic              rf_en_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  function automatic logic [2**ADDR_W-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = {{(2**ADDR_W-1){1'b0}}, 1'b1} << a;
  endfunction

  assign a_ready  = !rst && !a_full_s;
  assign b_ready  = !rst && !b_full_s;
  assign a_push_s = a_valid && a_ready;
  assign b_push_s = b_valid && b_ready;

  regfile_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(a_push_s), .pop(grant_a_s),
    .addr(a_addr), .data(a_data), .full(a_full_s), .empty(a_empty_s),
    .head_addr(a_head_addr_s), .head_data(a_head_data_s), .pend(a_pend_s)
  );

  regfile_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(b_push_s), .pop(grant_b_s),
    .addr(b_addr), .data(b_data), .full(b_full_s), .empty(b_empty_s),
    .head_addr(b_head_addr_s), .head_data(b_head_data_s), .pend(b_pend_s)
  );

  // Round-robin pick; rr only matters when both sides hold entries
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    contend_s = !hold && !a_empty_s && !b_empty_s;
    if (!hold && !a_empty_s && (b_empty_s || rr_r == RR_A)) begin
      grant_a_s = 1'b1;
    end else if (!hold && !b_empty_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
  end

  // Registered write stage and rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r       <= RR_A;
      rf_en_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      rf_en_r <= grant_a_s || grant_b_s;
      if (grant_a_s) begin
        rf_waddr_r <= a_head_addr_s;
        rf_wdata_r <= a_head_data_s;
      end else if (grant_b_s) begin
        rf_waddr_r <= b_head_addr_s;
        rf_wdata_r <= b_head_data_s;
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
      if (contend_s) begin
        rr_r <= (rr_r == RR_A) ? RR_B : RR_A;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

  assign rf_en    = rf_en_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign pending  = rst ? {NREG{1'b0}}
                        : (a_pend_s | b_pend_s | (rf_en_r ? onehot(rf_waddr_r) : {NREG{1'b0}}));
  assign idle     = rst || (a_empty_s && b_empty_s && !rf_en_r);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-based reference model, separate rf_* monitor.

module tb_regfile_wb_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREG   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, rf_en, idle;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0] pending;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .hold(hold), .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t qa[$], qb[$], expq[$];
  bit  rr_is_b = 1'b0;
  bit  m_en = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] shadow [NREG];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whatever the DUT places on rf_* is compared with the scoreboard
  always @(negedge clk) begin
    wr_t e;
    check("rf_en", {31'd0, rf_en}, {31'd0, m_en});
    check("rf_waddr_held", {29'd0, rf_waddr}, {29'd0, m_addr});
    check("rf_wdata_held", {24'd0, rf_wdata}, {24'd0, m_data});
    if (rf_en === 1'b1) begin
      if (expq.size() == 0) begin
        check("rf_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("rf_order_addr", {29'd0, rf_waddr}, {29'd0, e.addr});
        check("rf_order_data", {24'd0, rf_wdata}, {24'd0, e.data});
      end
      shadow[rf_waddr] = rf_wdata;
    end
  end

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p = '0;
    foreach (qa[i]) p[qa[i].addr] = 1'b1;
    foreach (qb[i]) p[qb[i].addr] = 1'b1;
    if (m_en) p[m_addr] = 1'b1;
    return p;
  endfunction

  // One clock of stimulus: drive, check state-derived outputs, then advance the model
  task automatic step(input bit av, input int aa, input int ad,
                      input bit bv, input int ba, input int bd,
                      input bit h, input bit r);
    bit a_acc, b_acc, na, nb;
    int side;
    wr_t w;
    @(negedge clk);
    a_valid = av; a_addr = aa[ADDR_W-1:0]; a_data = ad[DATA_W-1:0];
    b_valid = bv; b_addr = ba[ADDR_W-1:0]; b_data = bd[DATA_W-1:0];
    hold = h; rst = r;
    #1;
    check("a_ready", {31'd0, a_ready}, {31'd0, (!r && qa.size() < DEPTH)});
    check("b_ready", {31'd0, b_ready}, {31'd0, (!r && qb.size() < DEPTH)});
    check("pending", {24'd0, pending}, r ? 32'd0 : {24'd0, model_pending()});
    check("idle", {31'd0, idle}, {31'd0, (r || (qa.size() == 0 && qb.size() == 0 && !m_en))});
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete();
      rr_is_b = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      a_acc = av && qa.size() < DEPTH;
      b_acc = bv && qb.size() < DEPTH;
      na = qa.size() > 0;
      nb = qb.size() > 0;
      side = 0;
      if (h || (!na && !nb)) side = 0;
      else if (na && nb) begin side = rr_is_b ? 2 : 1; rr_is_b = !rr_is_b; end
      else side = na ? 1 : 2;
      m_en = (side != 0);
      if (side != 0) begin
        w = (side == 1) ? qa.pop_front() : qb.pop_front();
        m_addr = w.addr; m_data = w.data;
        expq.push_back(w);
      end
      if (a_acc) begin w.addr = aa[ADDR_W-1:0]; w.data = ad[DATA_W-1:0]; qa.push_back(w); end
      if (b_acc) begin w.addr = ba[ADDR_W-1:0]; w.data = bd[DATA_W-1:0]; qb.push_back(w); end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) shadow[i] = '0;
    // 1: single A write, latency and pending window
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 3, 8'h5A, 0, 0, 0, 0, 0);
    idle_cycles(4);
    check("t1_shadow_r3", {24'd0, shadow[3]}, 32'h5A);
    // 2: sustained contention alternates A,B
    for (int i = 0; i < 8; i++) step(1, 1, 8'h10 + i, 1, 2, 8'h80 + i, 0, 0);
    idle_cycles(6);
    // 3: fill A under hold, overflow push ignored, then drain
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i <= DEPTH; i++) step(1, 4, 8'h30 + i, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle_cycles(4);
    // 4: same register from A then B, later grant wins
    step(1, 5, 8'h11, 0, 0, 0, 0, 0);
    idle_cycles(3);
    step(0, 0, 0, 1, 5, 8'h22, 0, 0);
    idle_cycles(4);
    check("t4_shadow_r5", {24'd0, shadow[5]}, 32'h22);
    // 5: reset mid-drain discards queued writes
    step(1, 1, 8'hA1, 1, 2, 8'hB2, 0, 0);
    step(1, 6, 8'hA6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycles(5);
    // 6: tie sets rr=B, B-only traffic keeps it, next tie grants B then A
    step(1, 1, 8'h01, 1, 2, 8'h02, 0, 0);
    idle_cycles(4);
    step(0, 0, 0, 1, 3, 8'h03, 0, 0);
    idle_cycles(4);
    step(1, 4, 8'h04, 1, 6, 8'h06, 0, 0);
    idle_cycles(4);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end
    idle_cycles(8);
    check("final_scoreboard_empty", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
